// File: rtl/alarm_pio_pkg.sv
// ---------------------------------------------------------------------------
// alarm_pio_pkg: register map and edge-selection helpers for alarm_button_pio
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package alarm_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_type_e;

  // Unknown encodings capture nothing rather than guessing a direction.
  function automatic logic [31:0] edge_select(
    input logic [1:0]  kind,
    input logic [31:0] rise,
    input logic [31:0] fall
  );
    logic [31:0] hit;
    hit = '0;
    case (kind)
      EDGE_RISE: hit = rise;
      EDGE_FALL: hit = fall;
      EDGE_ANY:  hit = rise | fall;
      default:   hit = '0;
    endcase
    return hit;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pio_debounce.sv
// ---------------------------------------------------------------------------
// pio_debounce: one-bit two-flop synchronizer followed by a stability counter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pio_debounce #(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic IDLE_BIT        = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic deb
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             state_q, state_d;

  // The count qualifies the stage-one sample, so the settled level is taken
  // from stage two one cycle later; with at least two cycles required both
  // stages already agree when the new level is accepted.
  always_comb begin
    sync1_d = pin;
    sync2_d = sync1_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    if (sync1_q == state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      state_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= IDLE_BIT;
      sync2_q <= IDLE_BIT;
      cnt_q   <= '0;
      state_q <= IDLE_BIT;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign deb = state_q;

endmodule

`default_nettype wire

// File: rtl/alarm_button_pio.sv
// ---------------------------------------------------------------------------
// alarm_button_pio: debounced button/switch input port with edge capture and irq
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alarm_button_pio
  import alarm_pio_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] IDLE_LEVEL      = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [1:0] EDGE_KIND = 2'(EDGE_TYPE);

  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] deb_dly_q, deb_dly_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0] rise, fall, edge_hit, cap_clr;
  logic             wr_en;
  logic             unused_wdata;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      pio_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .IDLE_BIT        (IDLE_LEVEL[i])
      ) u_debounce (
        .clk     (clk),
        .reset_n (reset_n),
        .pin     (in_port[i]),
        .deb     (deb[i])
      );
    end
  endgenerate

  assign unused_wdata = ^writedata;

  // A capture landing in the same cycle as its W1C clear survives the clear.
  always_comb begin
    wr_en      = chipselect && !write_n;
    rise       = deb & ~deb_dly_q;
    fall       = ~deb & deb_dly_q;
    edge_hit   = WIDTH'(edge_select(EDGE_KIND, 32'(rise), 32'(fall)));
    cap_clr    = (wr_en && (address == ADDR_EDGECAP)) ? writedata[WIDTH-1:0] : '0;
    deb_dly_d  = deb;
    edge_cap_d = (edge_cap_q & ~cap_clr) | edge_hit;
    irq_mask_d = irq_mask_q;
    if (wr_en && (address == ADDR_IRQMASK)) begin
      irq_mask_d = writedata[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_dly_q  <= IDLE_LEVEL;
      irq_mask_q <= '0;
      edge_cap_q <= '0;
    end else begin
      deb_dly_q  <= deb_dly_d;
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata[WIDTH-1:0] = deb;
      ADDR_IRQMASK: readdata[WIDTH-1:0] = irq_mask_q;
      ADDR_EDGECAP: readdata[WIDTH-1:0] = edge_cap_q;
      default:      readdata = '0;
    endcase
  end

  assign irq = |(edge_cap_q & irq_mask_q);

endmodule

`default_nettype wire

// File: tb/tb_alarm_button_pio.sv
// ---------------------------------------------------------------------------
// tb_alarm_button_pio: directed and random stimulus against a window-based model
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_alarm_button_pio;
  import alarm_pio_pkg::*;

  localparam int               WIDTH = 4;
  localparam int               DEB   = 4;
  localparam int               ETYPE = 1;
  localparam logic [WIDTH-1:0] IDLE  = 4'hF;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [1:0]       address = 2'd0;
  logic             chipselect = 1'b0;
  logic             write_n = 1'b1;
  logic [31:0]      writedata = 32'd0;
  logic [WIDTH-1:0] in_port = IDLE;
  logic [31:0]      readdata;
  logic             irq;

  always #5 clk = ~clk;

  alarm_button_pio #(
    .WIDTH           (WIDTH),
    .DEBOUNCE_CYCLES (DEB),
    .EDGE_TYPE       (ETYPE),
    .IDLE_LEVEL      (IDLE)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Model: a level is accepted once the last DEB synchronizer samples all
  // disagree with it; a flag is raised the cycle after an accepted change.
  logic [WIDTH-1:0] m_deb, m_prev, m_mask, m_ecap;
  logic [WIDTH-1:0] m_hist[$];
  logic [WIDTH-1:0] m_flip, m_caught, m_clr;
  bit               m_steady;

  task automatic model_reset();
    m_deb  = IDLE;
    m_prev = IDLE;
    m_mask = '0;
    m_ecap = '0;
    m_hist.delete();
    for (int i = 0; i < DEB; i++) m_hist.push_back(IDLE);
  endtask

  always @(posedge clk) begin
    if (!reset_n) begin
      model_reset();
    end else begin
      for (int b = 0; b < WIDTH; b++) begin
        m_steady = 1'b1;
        for (int i = 0; i < m_hist.size(); i++)
          if (m_hist[i][b] == m_deb[b]) m_steady = 1'b0;
        m_flip[b] = m_steady;
        m_caught[b] = 1'b0;
        if (m_deb[b] != m_prev[b]) begin
          if (ETYPE == 2) m_caught[b] = 1'b1;
          else if (ETYPE == 1) m_caught[b] = !m_deb[b];
          else if (ETYPE == 0) m_caught[b] = m_deb[b];
        end
      end
      m_clr = (chipselect && !write_n && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
      m_ecap = (m_ecap & ~m_clr) | m_caught;
      if (chipselect && !write_n && address == 2'd2) m_mask = writedata[WIDTH-1:0];
      m_prev = m_deb;
      m_deb  = m_deb ^ m_flip;
      m_hist.push_back(in_port);
      if (m_hist.size() > DEB) void'(m_hist.pop_front());
    end
  end

  logic [31:0] snap [4];
  logic        snap_irq;

  task automatic check_all(input string ph);
    logic [31:0] exp;
    chipselect = 1'b0;
    write_n    = 1'b1;
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #0.5;
      case (a)
        0:       exp = 32'(m_deb);
        1:       exp = 32'd0;
        2:       exp = 32'(m_mask);
        default: exp = 32'(m_ecap);
      endcase
      snap[a] = readdata;
      check($sformatf("%s rd%0d", ph, a), readdata, exp);
    end
    snap_irq = irq;
    check({ph, " irq"}, 32'(irq), 32'(|(m_ecap & m_mask)));
  endtask

  task automatic cycle(input string ph);
    @(posedge clk);
    @(negedge clk);
    check_all(ph);
  endtask

  task automatic cycles(input int n, input string ph);
    for (int i = 0; i < n; i++) cycle(ph);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    cycle("wr");
  endtask

  int tog;

  initial begin
    cycles(2, "rst");
    reset_n = 1'b1;
    cycles(3, "idle");
    check("reset data", snap[0], 32'hF);
    check("reset mask", snap[2], 32'h0);
    check("reset ecap", snap[3], 32'h0);
    check("reset irq", 32'(snap_irq), 32'h0);

    in_port = 4'hD;
    cycles(3, "glitch");
    in_port = 4'hF;
    cycles(8, "glitch");
    check("glitch data", snap[0], 32'hF);
    check("glitch ecap", snap[3], 32'h0);

    wr(ADDR_IRQMASK, 32'h1);
    check("mask wr", snap[2], 32'h1);
    in_port = 4'hE;
    cycles(4, "fall0");
    check("fall0 data t+4", snap[0], 32'hF);
    cycle("fall0");
    check("fall0 data t+5", snap[0], 32'hE);
    check("fall0 ecap t+5", snap[3], 32'h0);
    cycle("fall0");
    check("fall0 ecap t+6", snap[3], 32'h1);
    check("fall0 irq t+6", 32'(snap_irq), 32'h1);

    in_port = 4'hA;
    cycles(6, "fall2");
    check("fall2 ecap", snap[3], 32'h5);
    wr(ADDR_IRQMASK, 32'h4);
    check("mask4 irq", 32'(snap_irq), 32'h1);
    wr(ADDR_EDGECAP, 32'h4);
    check("w1c ecap", snap[3], 32'h1);
    check("w1c irq", 32'(snap_irq), 32'h0);

    in_port = 4'hE;
    cycles(8, "rise2");
    check("rise ignored", snap[3], 32'h1);
    in_port = 4'hA;
    cycles(5, "sim");
    wr(ADDR_EDGECAP, 32'h4);
    check("set wins ecap", snap[3], 32'h5);
    check("set wins irq", 32'(snap_irq), 32'h1);

    in_port = 4'h2;
    cycles(3, "midcnt");
    reset_n = 1'b0;
    cycle("inrst");
    check("rst data", snap[0], 32'hF);
    check("rst mask", snap[2], 32'h0);
    check("rst ecap", snap[3], 32'h0);
    check("rst irq", 32'(snap_irq), 32'h0);
    cycle("inrst");
    reset_n = 1'b1;
    cycles(4, "post");
    check("post data t+4", snap[0], 32'hF);
    cycle("post");
    check("post data t+5", snap[0], 32'h2);
    check("post ecap t+5", snap[3], 32'h0);
    cycle("post");
    check("post ecap t+6", snap[3], 32'hD);

    tog = 4;
    for (int n = 0; n < 3000; n++) begin
      if (n % 50 == 0) begin
        case ($urandom_range(0, 2))
          0:       tog = 1;
          1:       tog = 5;
          default: tog = 15;
        endcase
      end
      if ($urandom_range(0, 399) == 0) begin
        reset_n = 1'b0;
        cycle("rnd rst");
        reset_n = 1'b1;
      end
      for (int b = 0; b < WIDTH; b++)
        if ($urandom_range(0, tog) == 0) in_port[b] = ~in_port[b];
      if ($urandom_range(0, 3) == 0) begin
        chipselect = ($urandom_range(0, 3) != 0);
        write_n    = 1'b0;
        address    = 2'($urandom_range(0, 3));
        writedata  = $urandom;
      end
      cycle("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alarm_button_pio.md
# alarm_button_pio

Avalon-MM slave input port for the alarm clock's push-buttons and switches; the read-side counterpart of the write-only buzzer output port. It synchronizes and debounces WIDTH external inputs and latches selected edges in a sticky capture register. It raises a maskable level interrupt to the Nios II CPU, which uses it for set-time, set-alarm and snooze events.

## Interface
- WIDTH, 4, number of input bits (1..32)
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before a level change is accepted (1 ms at 50 MHz; ≥2)
- EDGE_TYPE, 1, edges captured: 0 rising, 1 falling, 2 any
- IDLE_LEVEL, {WIDTH{1'b1}}, reset value of synchronizer and debounced state (buttons are active-low)
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  2  register word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- in_port  in  WIDTH  raw asynchronous pins
- readdata  out  32  read data, zero-extended, combinational from address
- irq  out  1  level interrupt, active-high

## Operation
- Register map (word addresses):
  - 0 DATA, RO: debounced levels.
  - 1: reads 0, writes ignored.
  - 2 IRQMASK, RW: WIDTH bits.
  - 3 EDGECAP, R/W1C: sticky edge flags.
- Writes take effect when chipselect && !write_n. Bits above WIDTH-1 read 0 and are ignored on write.
- Synchronizer: two flops per bit, reset to IDLE_LEVEL.
- Debouncer, per bit:
  - Counter cnt (width $clog2(DEBOUNCE_CYCLES)) and state deb (reset IDLE_LEVEL).
  - sync == deb: cnt <= 0.
  - sync != deb and cnt < DEBOUNCE_CYCLES-1: cnt++.
  - sync != deb and cnt == DEBOUNCE_CYCLES-1: deb <= sync, cnt <= 0.
  - Any glitch shorter than DEBOUNCE_CYCLES restarts the count.
- Edge detect: deb_q is deb delayed one cycle. rise = deb & ~deb_q, fall = ~deb & deb_q. The EDGE_TYPE selection sets EDGECAP bits.
- EDGECAP bit clears only when written 1 at address 3. If a set and a clear of the same bit happen in the same cycle, the set wins.
- irq = |(EDGECAP & IRQMASK), combinational from registers.
- Reset values:
  - DATA = IDLE_LEVEL.
  - IRQMASK = 0, EDGECAP = 0, irq = 0.
  - readdata reflects the current register contents.
- Reset mid-debounce discards the partial count. No edge is generated on reset deassertion.

## Timing
- Pin change stable from cycle t:
  - sync changes at t+2.
  - deb changes at t+1+DEBOUNCE_CYCLES.
  - EDGECAP bit set at t+2+DEBOUNCE_CYCLES.
  - irq high in the same cycle, if masked in.
- Reads: zero wait states. readdata is valid in the same cycle as address.
- W1C write in cycle c: bit reads 0 from c+1, irq drops at c+1 unless a new edge sets it in c.
- IRQMASK write: irq updates at c+1.

## Structure
- Package alarm_pio_pkg holds:
  - Address constants ADDR_DATA=0, ADDR_IRQMASK=2, ADDR_EDGECAP=3.
  - EDGE_RISE/EDGE_FALL/EDGE_ANY encodings.
- Sub-module pio_debounce: one bit, synchronizer + counter + deb output, parameters DEBOUNCE_CYCLES and IDLE_BIT.
- Top generates WIDTH instances plus edge logic, registers and read mux.

## Test plan
- Reset with in_port=4'hF: read addr 0 → 0xF; addr 2, addr 3 → 0; irq=0; no edge after release.
- DEBOUNCE_CYCLES=4, EDGE_TYPE=1, IRQMASK=0x1: hold bit0 low from t.
  - Expect DATA=0xE from t+5.
  - Expect EDGECAP=0x1 and irq=1 at t+6.
- Glitch: bit1 low for 3 cycles (DEBOUNCE_CYCLES=4) → DATA stays 0xF, EDGECAP stays 0.
- W1C: EDGECAP=0x5, write 0x4 to addr 3 → reads 0x1. irq follows the mask: with IRQMASK=0x4, irq drops the next cycle.
- Simultaneous: bit2 edge lands in the same cycle as a W1C of bit2 → EDGECAP bit2 remains 1.
- Assert reset_n mid-count (cnt=2): all state returns to reset values. A pin held low after release needs the full 4 cycles again.
